// File: rtl/disp_pkg.sv
// disp_pkg: shared display definitions for the front-panel scan logic.
//   SEG_W          : width of one GFEDCBA digit pattern
//   SEG_0..SEG_F   : hex glyphs, bit order GFEDCBA, 1 = lit
//   SEG_OFF        : all segments unlit (logical polarity)
//   scan_state_t   : per-slot scan state (BLANK / DRIVE)
//   seg_phys()     : map a logical pattern onto the physical bus polarity
package disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h71;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low segment buses carry the inverted pattern.
    function automatic logic [SEG_W-1:0] seg_phys(input logic [SEG_W-1:0] pat,
                                                  input logic             active_low);
        logic [SEG_W-1:0] res;
        if (active_low) begin
            res = ~pat;
        end else begin
            res = pat;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// seg_blink_gen: free-running blink phase generator.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (phase returns to 0 = visible)
//   o_phase  : blink phase, toggles every BLINK_DIV cycles
module seg_blink_gen #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_phase
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Half-period counter; phase flips on every wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan driver.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   digit_seg    : per-digit GFEDCBA patterns, digit i on [7i+6:7i], 1 = lit
//   digit_en     : per-digit enable (0 keeps the digit dark)
//   blink_mask   : per-digit blink select
//   seg_out      : registered physical segment bus (polarity ACTIVE_LOW_SEG)
//   an_out       : registered physical anode selects (polarity ACTIVE_LOW_AN)
//   frame_start  : registered one-cycle pulse at snapshot / start of slot 0
// Inputs are captured once per frame so a frame never mixes old and new data;
// each digit slot opens with a blank interval to suppress ghosting.
module seg_scan_driver
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100_000,
    parameter int BLANK_CYCLES   = 1_000,
    parameter int BLINK_DIV      = 25_000_000,
    parameter bit ACTIVE_LOW_AN  = 1'b1,
    parameter bit ACTIVE_LOW_SEG = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W*NUM_DIGITS-1:0] digit_seg,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_start
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]     SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]      SEG_UNLIT  = seg_phys(SEG_OFF, ACTIVE_LOW_SEG);

    logic [SLOT_W-1:0]                 r_slot_cnt;
    logic [IDX_W-1:0]                  r_digit_idx;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  r_snap_seg;
    logic [NUM_DIGITS-1:0]             r_snap_en;
    logic [NUM_DIGITS-1:0]             r_snap_blink;
    logic                              r_phase_snap;
    scan_state_t                       r_state;
    logic [SEG_W-1:0]                  r_seg_out;
    logic [NUM_DIGITS-1:0]             r_an_out;
    logic                              r_frame_start;

    logic                              w_phase;
    logic                              w_frame_now;
    logic                              w_show;
    logic [NUM_DIGITS-1:0]             w_an_onehot;
    logic [NUM_DIGITS-1:0]             w_an_drive;
    logic [SEG_W-1:0]                  w_seg_drive;

    seg_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_phase (w_phase)
    );

    // Counter position (slot 0, digit 0) is the first cycle of a frame.
    assign w_frame_now = (r_slot_cnt == '0) && (r_digit_idx == '0);

    // Slot and digit counters; the digit advances on every slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt <= '0;
            if (r_digit_idx == IDX_LAST) begin
                r_digit_idx <= '0;
            end else begin
                r_digit_idx <= r_digit_idx + IDX_W'(1);
            end
        end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // Frame snapshot; w_phase is the pre-toggle value if the blink wraps here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_seg    <= '0;
            r_snap_en     <= '0;
            r_snap_blink  <= '0;
            r_phase_snap  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_frame_now) begin
            r_snap_seg    <= digit_seg;
            r_snap_en     <= digit_en;
            r_snap_blink  <= blink_mask;
            r_phase_snap  <= w_phase;
            r_frame_start <= 1'b1;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    // Drive-phase output values; a hidden digit looks exactly like BLANK.
    always_comb begin
        w_show      = 1'b0;
        w_an_onehot = '0;
        w_an_drive  = AN_OFF;
        w_seg_drive = SEG_UNLIT;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_onehot[i] = (r_digit_idx == IDX_W'(i));
        end
        w_show = r_snap_en[r_digit_idx] && !(r_snap_blink[r_digit_idx] && r_phase_snap);
        if (w_show) begin
            w_an_drive  = ACTIVE_LOW_AN ? ~w_an_onehot : w_an_onehot;
            w_seg_drive = seg_phys(r_snap_seg[r_digit_idx], ACTIVE_LOW_SEG);
        end else begin
            w_an_drive  = AN_OFF;
            w_seg_drive = SEG_UNLIT;
        end
    end

    // Per-slot BLANK/DRIVE FSM; anodes and segments always update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BLANK;
            r_an_out  <= AN_OFF;
            r_seg_out <= SEG_UNLIT;
        end else begin
            case (r_state)
                BLANK: begin
                    if (r_slot_cnt == SLOT_BLANK) begin
                        r_state   <= DRIVE;
                        r_an_out  <= w_an_drive;
                        r_seg_out <= w_seg_drive;
                    end else begin
                        r_an_out  <= AN_OFF;
                        r_seg_out <= SEG_UNLIT;
                    end
                end
                DRIVE: begin
                    if (r_slot_cnt == '0) begin
                        r_state   <= BLANK;
                        r_an_out  <= AN_OFF;
                        r_seg_out <= SEG_UNLIT;
                    end else begin
                        r_an_out  <= w_an_drive;
                        r_seg_out <= w_seg_drive;
                    end
                end
                default: begin
                    r_state   <= BLANK;
                    r_an_out  <= AN_OFF;
                    r_seg_out <= SEG_UNLIT;
                end
            endcase
        end
    end

    assign seg_out     = r_seg_out;
    assign an_out      = r_an_out;
    assign frame_start = r_frame_start;

endmodule
